// File: rtl/midi_note_transmitter_pkg.sv
// Shared types and constants for the outbound MIDI note path.
package midi_note_transmitter_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } note_status_t;

    typedef struct packed {
        note_status_t status;
        logic [7:0]   note_number;
        logic [7:0]   velocity;
    } note_change_t;

    typedef logic [7:0] midi_byte_t;

    localparam logic [3:0]  NOTE_ON_STATUS  = 4'h9;
    localparam logic [3:0]  NOTE_OFF_STATUS = 4'h8;
    localparam int unsigned MIDI_BAUD       = 31_250;

    typedef enum logic [1:0] {
        IDLE,
        SEND_STATUS,
        SEND_DATA1,
        SEND_DATA2
    } tx_state_t;

    function automatic midi_byte_t status_byte(input note_status_t s, input logic [3:0] ch);
        return {(s == ON) ? NOTE_ON_STATUS : NOTE_OFF_STATUS, ch};
    endfunction

    // Data bytes never carry bit 7; it marks status bytes on the wire.
    function automatic midi_byte_t data_byte(input logic [7:0] x);
        return x & 8'h7F;
    endfunction

endpackage

// File: rtl/midi_note_transmitter_if.sv
// Valid/ready note-event channel into the MIDI transmitter.
interface midi_note_transmitter_if;
    import midi_note_transmitter_pkg::*;

    note_change_t note;
    logic         note_valid;
    logic         note_ready;

    modport master (output note, output note_valid, input  note_ready);
    modport slave  (input  note, input  note_valid, output note_ready);
endinterface

// File: rtl/midi_uart_tx.sv
// 8N1 byte serialiser; a byte offered during the last stop-bit cycle starts with no gap.
module midi_uart_tx
    import midi_note_transmitter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  midi_byte_t byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_c_o,
    output logic       done_c_o,
    output logic       tx_o
);

    localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     STOP_IDX = 4'd9;

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_idx_q;
    logic [8:0]       shift_q;
    logic             tx_q;
    logic             last_c;
    logic             load_c;

    assign last_c         = active_q && (cnt_q == CNT_LAST) && (bit_idx_q == STOP_IDX);
    assign byte_ready_c_o = !active_q || last_c;
    assign done_c_o       = last_c;
    assign load_c         = byte_valid_i && byte_ready_c_o;
    assign tx_o           = tx_q;

    // shift_q holds {stop, d7..d0}; its LSB is the next bit to drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '1;
            tx_q      <= 1'b1;
        end else if (load_c) begin
            active_q  <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= {1'b1, byte_i};
            tx_q      <= 1'b0;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                if (bit_idx_q == STOP_IDX) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    tx_q      <= shift_q[0];
                    shift_q   <= {1'b1, shift_q[8:1]};
                    bit_idx_q <= bit_idx_q + 4'd1;
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/midi_note_transmitter.sv
// Note event -> 3-byte Note On/Off message -> 31.25 kbaud MIDI line.
// MIDI_TX_RUNNING_STATUS_EN: omit the status byte when it repeats the last one sent.
module midi_note_transmitter
    import midi_note_transmitter_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 50_000_000,
    parameter int unsigned BAUD     = MIDI_BAUD,
    parameter int unsigned CHANNEL  = 0
) (
    input  logic                    clock_50_000_000,
    input  logic                    reset,
    midi_note_transmitter_if.slave  note_if,
    output logic                    midi_tx,
    output logic                    busy
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam logic [3:0]  CHAN         = 4'(CHANNEL);

    tx_state_t  state_q, state_d;
    logic       note_ready_q;
    logic       busy_q;
    midi_byte_t data1_q, data2_q;

    midi_byte_t status_c;
    midi_byte_t byte_c;
    logic       byte_valid_c;
    logic       byte_ready_c;
    logic       done_c;
    logic       accept_c;
    logic       skip_c;

    assign status_c = status_byte(note_if.note.status, CHAN);
    assign accept_c = note_if.note_valid && note_ready_q && byte_ready_c;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    midi_byte_t cache_q;
    logic       cache_valid_q;

    assign skip_c = cache_valid_q && (cache_q == status_c);

    // Only reset invalidates the cache; an aborted message leaves nothing to trust.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            cache_q       <= '0;
            cache_valid_q <= 1'b0;
        end else if (accept_c && !skip_c) begin
            cache_q       <= status_c;
            cache_valid_q <= 1'b1;
        end
    end
`else
    assign skip_c = 1'b0;
`endif

    // Next byte is handed over in the same cycle the serialiser frees up, keeping bytes contiguous.
    always_comb begin
        state_d      = state_q;
        byte_valid_c = 1'b0;
        byte_c       = '0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    byte_valid_c = 1'b1;
                    if (skip_c) begin
                        byte_c  = data_byte(note_if.note.note_number);
                        state_d = SEND_DATA1;
                    end else begin
                        byte_c  = status_c;
                        state_d = SEND_STATUS;
                    end
                end
            end
            SEND_STATUS: begin
                if (done_c) begin
                    byte_valid_c = 1'b1;
                    byte_c       = data1_q;
                    state_d      = SEND_DATA1;
                end
            end
            SEND_DATA1: begin
                if (done_c) begin
                    byte_valid_c = 1'b1;
                    byte_c       = data2_q;
                    state_d      = SEND_DATA2;
                end
            end
            SEND_DATA2: begin
                if (done_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // note_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            note_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            data1_q      <= '0;
            data2_q      <= '0;
        end else begin
            state_q      <= state_d;
            note_ready_q <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
            if (accept_c) begin
                data1_q <= data_byte(note_if.note.note_number);
                data2_q <= data_byte(note_if.note.velocity);
            end
        end
    end

    midi_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk            (clock_50_000_000),
        .rst            (reset),
        .byte_i         (byte_c),
        .byte_valid_i   (byte_valid_c),
        .byte_ready_c_o (byte_ready_c),
        .done_c_o       (done_c),
        .tx_o           (midi_tx)
    );

    assign note_if.note_ready = note_ready_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_midi_note_transmitter.sv
// Directed bench: two transmitters (channel 0 and 5) with UART line decoders feeding a byte scoreboard.
module tb_midi_note_transmitter;
    import midi_note_transmitter_pkg::*;

    localparam int unsigned CPB      = 16;
    localparam int unsigned CLK_HZ   = MIDI_BAUD * CPB;
    localparam int unsigned BYTE_CYC = 10 * CPB;
    localparam int unsigned BOUND    = 2000;

    typedef struct {
        int unsigned inst;
        midi_byte_t  b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx0, tx5, busy0, busy5;
    logic [1:0] txv;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned rst_epoch = 0;
    exp_t        expq[$];
    midi_byte_t  m_cache[2];
    bit          m_cv[2];

    midi_note_transmitter_if if0 ();
    midi_note_transmitter_if if5 ();

    midi_note_transmitter #(.CLOCK_HZ(CLK_HZ), .BAUD(MIDI_BAUD), .CHANNEL(0)) dut0 (
        .clock_50_000_000 (clk),
        .reset            (rst),
        .note_if          (if0),
        .midi_tx          (tx0),
        .busy             (busy0)
    );

    midi_note_transmitter #(.CLOCK_HZ(CLK_HZ), .BAUD(MIDI_BAUD), .CHANNEL(5)) dut5 (
        .clock_50_000_000 (clk),
        .reset            (rst),
        .note_if          (if5),
        .midi_tx          (tx5),
        .busy             (busy5)
    );

    always #5 clk = ~clk;
    assign txv = {tx5, tx0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic note_change_t mk(input note_status_t s, input logic [7:0] nn, input logic [7:0] vel);
        note_change_t n;
        n.status = s;
        n.note_number = nn;
        n.velocity = vel;
        return n;
    endfunction

    // Reference encoder: queues the bytes a message should produce, returns byte count.
    function automatic int unsigned push_msg(input int sel, input note_change_t n);
        midi_byte_t  st;
        midi_byte_t  nn;
        midi_byte_t  vel;
        int unsigned nb;
        logic [3:0]  ch;
        ch  = (sel == 0) ? 4'd0 : 4'd5;
        st  = {(n.status == ON) ? 4'h9 : 4'h8, ch};
        nn  = n.note_number;
        vel = n.velocity;
        nb  = 3;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (m_cv[sel] && m_cache[sel] == st) begin
            nb = 2;
        end else begin
            expq.push_back('{32'(sel), st});
            m_cache[sel] = st;
            m_cv[sel]    = 1'b1;
        end
`else
        expq.push_back('{32'(sel), st});
`endif
        expq.push_back('{32'(sel), {1'b0, nn[6:0]}});
        expq.push_back('{32'(sel), {1'b0, vel[6:0]}});
        return nb;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if0.note_ready : if5.note_ready;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 0) ? busy0 : busy5;
    endfunction

    function automatic logic txl(input int sel);
        return (sel == 0) ? tx0 : tx5;
    endfunction

    task automatic drive(input int sel, input note_change_t n, input logic v);
        if (sel == 0) begin
            if0.note = n;
            if0.note_valid = v;
        end else begin
            if5.note = n;
            if5.note_valid = v;
        end
    endtask

    // Call at a negedge with valid high; returns half a cycle after the accepting edge.
    task automatic accept(input int sel, output int unsigned waited);
        waited = 0;
        while (rdy(sel) !== 1'b1 && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        total++;
        assert (rdy(sel) === 1'b1) else begin
            bad++;
            $error("FAIL accept_timeout observed=%0b expected=1", rdy(sel));
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int sel, output int unsigned n);
        n = 0;
        while (bsy(sel) === 1'b1 && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Mid-bit sampling line decoders; bytes cut short by a reset are discarded.
    for (genvar g = 0; g < 2; g++) begin : g_rx
        always begin : rx
            midi_byte_t  b;
            logic        start_ok;
            logic        stop;
            int unsigned ep;
            exp_t        e;
            @(negedge clk);
            if (!rst && txv[g] === 1'b0) begin
                ep = rst_epoch;
                b  = '0;
                repeat (CPB / 2) @(negedge clk);
                start_ok = (txv[g] === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txv[g];
                end
                repeat (CPB) @(negedge clk);
                stop = txv[g];
                if (ep == rst_epoch) begin
                    check("rx_framing", 32'({start_ok, stop}), 32'(2'b11));
                    total++;
                    assert (expq.size() != 0) else begin
                        bad++;
                        $error("FAIL rx_unexpected observed=0x%0h expected=none", b);
                    end
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        check("rx_inst", 32'(g), e.inst);
                        check("rx_byte", 32'(b), 32'(e.b));
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  w, n, na, nb, nc;
        note_change_t a, b, c;
        m_cv = '{1'b0, 1'b0};
        drive(0, mk(OFF, 8'd0, 8'd0), 1'b0);
        drive(1, mk(OFF, 8'd0, 8'd0), 1'b0);

        // T1 reset and idle
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_ready", 32'(if0.note_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(if0.note_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("idle_tx", 32'(tx0), 32'd1);
        check("idle_busy", 32'(busy0), 32'd0);
        check("idle_ready", 32'(if0.note_ready), 32'd1);

        // T2 ON 60/100 on channel 0
        a  = mk(ON, 8'd60, 8'd100);
        na = push_msg(0, a);
        drive(0, a, 1'b1);
        accept(0, w);
        drive(0, a, 1'b0);
        check("t2_wait", w, 32'd0);
        check("t2_tx_start", 32'(tx0), 32'd0);
        check("t2_ready_low", 32'(if0.note_ready), 32'd0);
        wait_idle(0, n);
        check("t2_busy_len", n, na * BYTE_CYC);
        check("t2_ready_back", 32'(if0.note_ready), 32'd1);
        repeat (CPB) @(negedge clk);
        check("t2_drained", 32'(expq.size()), 32'd0);

        // T3 OFF with out-of-range data on channel 5
        a  = mk(OFF, 8'hBC, 8'hFF);
        na = push_msg(1, a);
        drive(1, a, 1'b1);
        accept(1, w);
        drive(1, a, 1'b0);
        check("t3_tx_start", 32'(tx5), 32'd0);
        wait_idle(1, n);
        check("t3_busy_len", n, na * BYTE_CYC);
        repeat (CPB) @(negedge clk);
        check("t3_drained", 32'(expq.size()), 32'd0);

        // T4 back-to-back held events, then a status change
        rst = 1'b1;
        rst_epoch++;
        expq.delete();
        m_cv = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        a  = mk(ON, 8'h3C, 8'h64);
        b  = mk(ON, 8'h3E, 8'h64);
        c  = mk(OFF, 8'h3E, 8'h40);
        na = push_msg(0, a);
        drive(0, a, 1'b1);
        accept(0, w);
        check("t4_a_wait", w, 32'd0);
        nb = push_msg(0, b);
        drive(0, b, 1'b1);
        accept(0, w);
        check("t4_b_wait", w, na * BYTE_CYC);
        check("t4_b_tx_start", 32'(tx0), 32'd0);
        nc = push_msg(0, c);
        drive(0, c, 1'b1);
        accept(0, w);
        drive(0, c, 1'b0);
        check("t4_c_wait", w, nb * BYTE_CYC);
        wait_idle(0, n);
        check("t4_c_busy_len", n, nc * BYTE_CYC);
        repeat (CPB) @(negedge clk);
        check("t4_drained", 32'(expq.size()), 32'd0);

        // T5 valid raised mid-message is held off until idle
        a  = mk(ON, 8'h40, 8'h7F);
        b  = mk(ON, 8'h41, 8'h10);
        na = push_msg(0, a);
        drive(0, a, 1'b1);
        accept(0, w);
        drive(0, a, 1'b0);
        repeat (100) @(negedge clk);
        nb = push_msg(0, b);
        drive(0, b, 1'b1);
        check("t5_ready_low", 32'(if0.note_ready), 32'd0);
        check("t5_busy", 32'(busy0), 32'd1);
        accept(0, w);
        drive(0, b, 1'b0);
        check("t5_wait", w, na * BYTE_CYC - 100);
        check("t5_tx_start", 32'(tx0), 32'd0);
        wait_idle(0, n);
        check("t5_busy_len", n, nb * BYTE_CYC);
        repeat (CPB) @(negedge clk);
        check("t5_drained", 32'(expq.size()), 32'd0);

        // T6 reset during data1, then a full message
        a  = mk(OFF, 8'h45, 8'h20);
        na = push_msg(0, a);
        drive(0, a, 1'b1);
        accept(0, w);
        drive(0, a, 1'b0);
        repeat (BYTE_CYC + 3) @(negedge clk);
        check("t6_pre_tx", 32'(tx0), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_tx", 32'(tx0), 32'd1);
        check("t6_rst_busy", 32'(busy0), 32'd0);
        rst_epoch++;
        expq.delete();
        m_cv = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check("t6_rst_ready", 32'(if0.note_ready), 32'd0);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        b  = mk(ON, 8'h3C, 8'h64);
        nb = push_msg(0, b);
        drive(0, b, 1'b1);
        accept(0, w);
        drive(0, b, 1'b0);
        check("t6_wait", w, 32'd0);
        check("t6_tx_start", 32'(tx0), 32'd0);
        wait_idle(0, n);
        check("t6_busy_len", n, 3 * BYTE_CYC);
        check("t6_nbytes", nb, 32'd3);
        repeat (CPB) @(negedge clk);
        check("final_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
